// File: rtl/ps2_pkg.sv
// ps2_pkg: shared state encoding, scan-code prefixes and default timing for the PS/2 decoder
package ps2_pkg;
    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
    localparam logic [7:0] BREAK_CODE = 8'hF0;
    localparam logic [7:0] EXT_CODE = 8'hE0;
    localparam int DEF_FILTER_LEN = 8;
    localparam int DEF_TIMEOUT_CYCLES = 100000;
endpackage

// File: rtl/ps2_line_filter.sv
// ps2_line_filter: 2-FF synchronizer, glitch filter and falling-edge detect for one PS/2 line
module ps2_line_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic reset_n,
    input  logic line,
    output logic filt,
    output logic fall
);
    localparam int CW = $clog2(FILTER_LEN + 1);
    logic [1:0]    sync;
    logic [CW-1:0] cnt;
    logic          filt_d;
    // synchronize, then only follow the line once it has disagreed with filt for FILTER_LEN samples
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync   <= 2'b11;
            cnt    <= '0;
            filt   <= 1'b1;
            filt_d <= 1'b1;
        end else begin
            sync   <= {sync[0], line};
            filt_d <= filt;
            if (sync[1] == filt) cnt <= '0;
            else if (cnt == CW'(FILTER_LEN - 1)) begin
                filt <= sync[1];
                cnt  <= '0;
            end else cnt <= cnt + 1'b1;
        end
    end
    assign fall = filt_d & ~filt;
endmodule

// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder: PS/2 frame receiver reporting make codes and dropping release/extended sequences
module ps2_key_decoder
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN = DEF_FILTER_LEN,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] code,
    output logic       set_signal,
    output logic       err
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    state_t        state;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          parity_ok;
    logic [TW-1:0] tmo;
    logic          brk;
    logic          ext;
    logic          clk_filt;
    logic          clk_fall;
    logic          data_filt;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
        .clk(clk), .reset_n(reset_n), .line(ps2_clk), .filt(clk_filt), .fall(clk_fall)
    );
    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filter (
        .clk(clk), .reset_n(reset_n), .line(ps2_data), .filt(data_filt), .fall()
    );

    // frame FSM: one bit per filtered ps2_clk falling edge, timeout abandons partial frames
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            shreg      <= '0;
            parity_ok  <= 1'b0;
            tmo        <= '0;
            brk        <= 1'b0;
            ext        <= 1'b0;
            code       <= 8'h00;
            set_signal <= 1'b0;
            err        <= 1'b0;
        end else begin
            set_signal <= 1'b0;
            err        <= 1'b0;
            if (clk_fall) begin
                tmo <= '0;
                case (state)
                    IDLE: begin
                        if (!data_filt) begin
                            state   <= DATA;
                            bit_cnt <= '0;
                        end else err <= 1'b1;
                    end
                    DATA: begin
                        shreg   <= {data_filt, shreg[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) state <= PARITY;
                    end
                    PARITY: begin
                        parity_ok <= data_filt ^ (^shreg);
                        state     <= STOP;
                    end
                    STOP: begin
                        state <= IDLE;
                        if (data_filt && parity_ok) begin
                            if (shreg == BREAK_CODE) brk <= 1'b1;
                            else if (shreg == EXT_CODE) ext <= 1'b1;
                            else if (brk || ext) begin
                                brk <= 1'b0;
                                ext <= 1'b0;
                            end else begin
                                code       <= shreg;
                                set_signal <= 1'b1;
                            end
                        end else begin
                            err <= 1'b1;
                            brk <= 1'b0;
                            ext <= 1'b0;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end else if (state != IDLE) begin
                if (tmo == TW'(TIMEOUT_CYCLES - 1)) begin
                    err     <= 1'b1;
                    state   <= IDLE;
                    bit_cnt <= '0;
                    tmo     <= '0;
                    brk     <= 1'b0;
                    ext     <= 1'b0;
                end else tmo <= tmo + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_ps2_key_decoder.sv
// tb_ps2_key_decoder: directed PS/2 frames with a scoreboard checking every set_signal and err pulse
module tb_ps2_key_decoder;
    localparam int FLEN = 8;
    localparam int TMO = 500;
    localparam int HALF = 40;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] code;
    logic       set_signal;
    logic       err;

    logic [7:0] exp_q[$];
    int n_checks = 0;
    int n_fail = 0;
    int err_seen = 0;
    int err_exp = 0;
    logic prev_set = 1'b0;
    logic prev_err = 1'b0;

    ps2_key_decoder #(.FILTER_LEN(FLEN), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .reset_n(reset_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .code(code), .set_signal(set_signal), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        ps2_data = b;
        idle(HALF);
        ps2_clk = 1'b0;
        idle(HALF);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic flip);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(~(^b) ^ flip);
        send_bit(1'b1);
        ps2_data = 1'b1;
        idle(100);
    endtask

    task automatic checkpoint(input string name);
        check({name, "_err_count"}, err_seen, err_exp);
        check({name, "_pending"}, exp_q.size(), 0);
    endtask

    // monitor: pop one expected code per set_signal pulse, count err pulses, enforce one-cycle width
    always @(negedge clk) begin
        if (!reset_n) begin
            prev_set = 1'b0;
            prev_err = 1'b0;
        end else begin
            if (set_signal) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_set: code %0h with nothing expected", code);
                end else check("set_code", code, exp_q.pop_front());
                check("set_err_exclusive", err, 1'b0);
                check("set_width", prev_set, 1'b0);
            end
            if (err) begin
                err_seen++;
                check("err_width", prev_err, 1'b0);
            end
            prev_set = set_signal;
            prev_err = err;
        end
    end

    initial begin
        idle(3);
        check("reset_code", code, 8'h00);
        check("reset_set", set_signal, 1'b0);
        check("reset_err", err, 1'b0);
        reset_n = 1'b1;
        idle(20);

        exp_q.push_back(8'h1B);
        send_frame(8'h1B, 1'b0);
        checkpoint("make_1b");
        check("code_1b", code, 8'h1B);

        exp_q.push_back(8'h5A);
        send_frame(8'h5A, 1'b0);
        send_frame(8'hF0, 1'b0);
        send_frame(8'h1B, 1'b0);
        checkpoint("break");
        check("code_after_break", code, 8'h5A);

        send_frame(8'hE0, 1'b0);
        send_frame(8'h75, 1'b0);
        exp_q.push_back(8'h1C);
        send_frame(8'h1C, 1'b0);
        checkpoint("extended");

        send_frame(8'h1C, 1'b1);
        err_exp++;
        checkpoint("parity");
        exp_q.push_back(8'h1C);
        send_frame(8'h1C, 1'b0);
        exp_q.push_back(8'h1C);
        send_frame(8'h1C, 1'b0);
        checkpoint("typematic");

        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        ps2_data = 1'b1;
        idle(TMO + 1 + 100);
        err_exp++;
        checkpoint("timeout");
        exp_q.push_back(8'h34);
        send_frame(8'h34, 1'b0);
        checkpoint("after_timeout");
        check("code_34", code, 8'h34);

        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b1);
        reset_n = 1'b0;
        #1;
        check("midreset_code", code, 8'h00);
        check("midreset_set", set_signal, 1'b0);
        check("midreset_err", err, 1'b0);
        idle(5);
        reset_n = 1'b1;
        repeat (7) send_bit(1'b1);
        ps2_data = 1'b1;
        idle(100);
        err_exp += 7;
        checkpoint("midframe_reset");
        check("code_after_reset", code, 8'h00);

        ps2_clk = 1'b0;
        idle(3);
        ps2_clk = 1'b1;
        idle(60);
        checkpoint("glitch");
        check("code_after_glitch", code, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/ps2_key_decoder.md
PS2_KEY_DECODER -- requirements
Module: ps2_key_decoder

Interface
REQ-001 Parameter FILTER_LEN, default 8, clk cycles a PS/2 line must be stable before its filtered value changes.
REQ-002 Parameter TIMEOUT_CYCLES, default 100000, clk cycles without a falling ps2_clk edge before a partial frame is abandoned.
REQ-003 clk  input  1  system clock; all state on rising edge.
REQ-004 reset_n  input  1  reset, asynchronous and active-low.
REQ-005 ps2_clk  input  1  raw PS/2 clock line, asynchronous to clk.
REQ-006 ps2_data  input  1  raw PS/2 data line, asynchronous to clk.
REQ-007 code  output  8  last accepted make scan code; holds between key presses.
REQ-008 set_signal  output  1  one-cycle pulse; code is valid and new in this cycle.
REQ-009 err  output  1  one-cycle pulse on a parity, start-bit, stop-bit or timeout error.

Function
REQ-010 Each PS/2 line SHALL pass through a 2-FF synchronizer, then a glitch filter updating only after FILTER_LEN consecutive equal samples.
REQ-011 A sample event SHALL be one clk-cycle-wide and SHALL fire on each falling edge of filtered ps2_clk; filtered ps2_data is captured in that cycle.
REQ-012 Frame FSM states: IDLE, DATA, PARITY, STOP.
REQ-013 IDLE: sample with data=0 -> DATA with bit count cleared; sample with data=1 -> err pulse, stay in IDLE.
REQ-014 DATA: shift data in LSB-first; after the 8th bit -> PARITY.
REQ-015 PARITY: the captured bit plus the 8 data bits SHALL have odd parity; record pass/fail; -> STOP.
REQ-016 STOP: data=1 and parity passed -> frame byte accepted; otherwise err pulse and byte discarded; in both cases -> IDLE.
REQ-017 In any non-IDLE state, TIMEOUT_CYCLES cycles with no sample event -> err pulse, -> IDLE; the bit count SHALL NOT carry over into the next frame.
REQ-018 An accepted byte 8'hF0 SHALL set break_pending; 8'hE0 SHALL set ext_pending; neither pulses set_signal.
REQ-019 An accepted byte with break_pending or ext_pending set SHALL clear both flags and SHALL NOT update code or pulse set_signal (key releases and extended keys are ignored).
REQ-020 Any other accepted byte SHALL be loaded into code and pulse set_signal for exactly one cycle, with latency 1 clk after the stop-bit sample event.
REQ-021 Typematic repeats SHALL each produce a separate set_signal pulse with the same code.
REQ-022 err and set_signal SHALL never be asserted in the same cycle.
REQ-023 A frame error SHALL clear break_pending and ext_pending.

Reset
REQ-024 reset_n low SHALL immediately force: code=8'h00, set_signal=0, err=0, FSM=IDLE, bit count=0, flags clear, timeout counter=0, filter outputs=1 (idle bus).
REQ-025 Reset deasserted mid-frame SHALL cause the remaining bits of that frame to be treated as a new frame starting in IDLE; no spurious set_signal.

Structure
REQ-026 Package ps2_pkg SHALL hold the FSM state encoding, the prefix constants BREAK_CODE=8'hF0 and EXT_CODE=8'hE0, and the default FILTER_LEN/TIMEOUT_CYCLES values.
REQ-027 One sub-module, ps2_line_filter (synchronizer + glitch filter + falling-edge detect), SHALL be instantiated once per line; the edge output is used only for ps2_clk.

Verification
REQ-028 Frame for 8'h1B (start 0, data 1101_1000, parity 1, stop 1) -> code=8'h1B, set_signal high exactly 1 cycle, err=0.
REQ-029 Frames F0 then 1B following a 5A make -> code stays 8'h5A, no set_signal, no err.
REQ-030 Frames E0 then 75, then frame 1C -> only one set_signal, with code=8'h1C.
REQ-031 Frame 8'h1C with parity bit flipped -> err 1-cycle pulse, code unchanged, no set_signal; the next valid 8'h1C frame -> set_signal.
REQ-032 4 bits of a frame, then silence for TIMEOUT_CYCLES+1 -> one err pulse; a full 8'h34 frame follows -> code=8'h34 with set_signal.
REQ-033 reset_n pulsed low mid-frame, and a 3-cycle glitch on ps2_clk with FILTER_LEN=8 -> no sample event, no set_signal, outputs at reset values.
